// File: rtl/matchblock_pr_controller.sv
`default_nettype none
// ============================================================================
// Module   : matchblock_pr_controller
// Purpose  : Sequences partial reconfiguration of one match-block slot
//            (hold, drain, freeze, PR hand-off, settle, re-enable) and keeps
//            per-slot outstanding-work counters from snooped handshakes.
// Revision : 1.0  initial release
// ============================================================================
module matchblock_pr_controller #(
  parameter int NUM_BLOCKS    = 4,
  parameter int CNT_W         = 8,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int FREEZE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  avs_ctrl_write,
  input  logic                  avs_ctrl_read,
  input  logic [1:0]            avs_ctrl_address,
  input  logic [31:0]           avs_ctrl_writedata,
  output logic [31:0]           avs_ctrl_readdata,
  output logic [NUM_BLOCKS-1:0] coe_localfreeze,
  output logic                  coe_globalfreeze,
  output logic [NUM_BLOCKS-1:0] coe_enable,
  output logic [NUM_BLOCKS-1:0] hold_pnode,
  input  logic [NUM_BLOCKS-1:0] mon_pnode_valid,
  input  logic [NUM_BLOCKS-1:0] mon_pnode_ready,
  input  logic [NUM_BLOCKS-1:0] mon_data_valid,
  input  logic [NUM_BLOCKS-1:0] mon_data_ack,
  output logic                  pr_start,
  input  logic                  pr_done,
  input  logic                  pr_error
);

  localparam int WAIT_MAX0 = (DRAIN_TIMEOUT > FREEZE_CYCLES) ? DRAIN_TIMEOUT : FREEZE_CYCLES;
  localparam int WAIT_MAX  = (WAIT_MAX0 > SETTLE_CYCLES) ? WAIT_MAX0 : SETTLE_CYCLES;
  localparam int WAIT_W    = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_DRAIN  = 3'd2,
    S_FREEZE = 3'd3,
    S_PRWAIT = 3'd4,
    S_SETTLE = 3'd5,
    S_ENABLE = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t                state;
  logic [3:0]            target;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  err;
  logic                  timeout;
  logic                  ovf;
  logic                  unf;

  logic [CNT_W-1:0]      cnt     [NUM_BLOCKS];
  logic [CNT_W-1:0]      cnt_nxt [NUM_BLOCKS];
  logic [CNT_W-1:0]      tgt_cnt;
  logic [CNT_W-1:0]      tgt_cnt_nxt;
  logic                  ovf_set;
  logic                  unf_set;

  logic [NUM_BLOCKS-1:0] inc;
  logic [NUM_BLOCKS-1:0] dec;
  logic [NUM_BLOCKS-1:0] sel;
  logic [NUM_BLOCKS-1:0] wr_sel;
  logic [3:0]            wr_target;
  logic                  bad_target;
  logic                  wr_ctrl;
  logic                  wr_mask;
  logic                  start_req;
  logic                  clr_err;
  logic                  busy;
  logic [31:0]           status;
  logic                  unused_wdata;

  assign inc        = mon_pnode_valid & mon_pnode_ready;
  assign dec        = mon_data_valid & mon_data_ack;
  assign sel        = NUM_BLOCKS'(1) << target;
  assign wr_target  = avs_ctrl_writedata[7:4];
  assign wr_sel     = NUM_BLOCKS'(1) << wr_target;
  assign bad_target = {1'b0, wr_target} >= 5'(NUM_BLOCKS);
  assign wr_ctrl    = avs_ctrl_write && (avs_ctrl_address == 2'd0);
  assign wr_mask    = avs_ctrl_write && (avs_ctrl_address == 2'd1);
  assign start_req  = wr_ctrl && avs_ctrl_writedata[0];
  assign clr_err    = wr_ctrl && avs_ctrl_writedata[8];
  assign busy       = (state != S_IDLE);
  assign status     = {16'h0, ovf, unf, timeout, err, target, busy, state, 4'h0};
  assign unused_wdata = ^avs_ctrl_writedata;

  // Next counter values; the drain check looks at the next value so a final
  // ack is recognised in the same cycle it is snooped.
  always_comb begin
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    tgt_cnt     = '0;
    tgt_cnt_nxt = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (inc[i] && !dec[i]) begin
        if (cnt[i] == '1) ovf_set = 1'b1;
        else              cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end else if (dec[i] && !inc[i]) begin
        if (cnt[i] == '0) unf_set = 1'b1;
        else              cnt_nxt[i] = cnt[i] - CNT_W'(1);
      end
      if (target == 4'(i)) begin
        tgt_cnt     = cnt[i];
        tgt_cnt_nxt = cnt_nxt[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_BLOCKS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (state == S_ENABLE && target == 4'(i)) cnt[i] <= '0;
        else                                      cnt[i] <= cnt_nxt[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      target            <= '0;
      wait_cnt          <= '0;
      err               <= 1'b0;
      timeout           <= 1'b0;
      ovf               <= 1'b0;
      unf               <= 1'b0;
      coe_localfreeze   <= '0;
      coe_globalfreeze  <= 1'b0;
      coe_enable        <= '1;
      hold_pnode        <= '0;
      pr_start          <= 1'b0;
      avs_ctrl_readdata <= '0;
    end else begin
      pr_start <= 1'b0;

      // Flag sets below take priority over a simultaneous clear.
      if (clr_err) begin
        err     <= 1'b0;
        timeout <= 1'b0;
        ovf     <= 1'b0;
        unf     <= 1'b0;
      end
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) unf <= 1'b1;

      if (wr_mask && state == S_IDLE) coe_enable <= avs_ctrl_writedata[NUM_BLOCKS-1:0];

      if (avs_ctrl_read) begin
        case (avs_ctrl_address)
          2'd0:    avs_ctrl_readdata <= status;
          2'd1:    avs_ctrl_readdata <= 32'(coe_enable);
          2'd2:    avs_ctrl_readdata <= 32'(tgt_cnt);
          default: avs_ctrl_readdata <= '0;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start_req) begin
            if (bad_target) begin
              err <= 1'b1;
            end else begin
              target     <= wr_target;
              hold_pnode <= hold_pnode | wr_sel;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          wait_cnt <= '0;
          state    <= S_DRAIN;
        end
        S_DRAIN: begin
          if (tgt_cnt_nxt == '0) begin
            wait_cnt         <= '0;
            coe_enable       <= coe_enable & ~sel;
            coe_localfreeze  <= coe_localfreeze | sel;
            coe_globalfreeze <= 1'b1;
            state            <= S_FREEZE;
          end else if (wait_cnt == WAIT_W'(DRAIN_TIMEOUT - 1)) begin
            timeout    <= 1'b1;
            err        <= 1'b1;
            coe_enable <= coe_enable & ~sel;
            state      <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_FREEZE: begin
          if (wait_cnt == WAIT_W'(FREEZE_CYCLES - 1)) begin
            pr_start <= 1'b1;
            state    <= S_PRWAIT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_PRWAIT: begin
          if (pr_error) begin
            err   <= 1'b1;
            state <= S_ERROR;
          end else if (pr_done) begin
            wait_cnt <= '0;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1)) begin
            coe_localfreeze  <= coe_localfreeze & ~sel;
            coe_globalfreeze <= 1'b0;
            coe_enable       <= coe_enable | sel;
            hold_pnode       <= hold_pnode & ~sel;
            state            <= S_ENABLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_ENABLE: begin
          state <= S_IDLE;
        end
        S_ERROR: begin
          // The slot stays disabled until software re-enables it explicitly.
          if (clr_err) begin
            coe_localfreeze  <= coe_localfreeze & ~sel;
            coe_globalfreeze <= 1'b0;
            hold_pnode       <= hold_pnode & ~sel;
            state            <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matchblock_pr_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_matchblock_pr_controller
// Purpose  : Randomised scoreboard bench for matchblock_pr_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_matchblock_pr_controller;

  localparam int NB  = 4;
  localparam int FC  = 4;
  localparam int SC  = 16;
  localparam int TMO = 1024;

  localparam int K_RD  = 0;
  localparam int K_OUT = 1;
  localparam int K_PRS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        avs_ctrl_write = 1'b0;
  logic        avs_ctrl_read = 1'b0;
  logic [1:0]  avs_ctrl_address = 2'd0;
  logic [31:0] avs_ctrl_writedata = '0;
  logic [31:0] avs_ctrl_readdata;
  logic [NB-1:0] coe_localfreeze;
  logic        coe_globalfreeze;
  logic [NB-1:0] coe_enable;
  logic [NB-1:0] hold_pnode;
  logic [NB-1:0] pnv = '0;
  logic [NB-1:0] pnr = '0;
  logic [NB-1:0] dv = '0;
  logic [NB-1:0] dack = '0;
  logic        pr_start;
  logic        pr_done = 1'b0;
  logic        pr_error = 1'b0;

  always #5 clk = ~clk;

  matchblock_pr_controller #(
    .NUM_BLOCKS(NB), .CNT_W(8), .DRAIN_TIMEOUT(TMO),
    .FREEZE_CYCLES(FC), .SETTLE_CYCLES(SC)
  ) dut (
    .clock(clk), .reset(reset),
    .avs_ctrl_write(avs_ctrl_write), .avs_ctrl_read(avs_ctrl_read),
    .avs_ctrl_address(avs_ctrl_address), .avs_ctrl_writedata(avs_ctrl_writedata),
    .avs_ctrl_readdata(avs_ctrl_readdata),
    .coe_localfreeze(coe_localfreeze), .coe_globalfreeze(coe_globalfreeze),
    .coe_enable(coe_enable), .hold_pnode(hold_pnode),
    .mon_pnode_valid(pnv), .mon_pnode_ready(pnr),
    .mon_data_valid(dv), .mon_data_ack(dack),
    .pr_start(pr_start), .pr_done(pr_done), .pr_error(pr_error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model
  int       m_cnt [NB];
  bit       m_ovf, m_unf, m_err, m_to;
  int       m_target;
  logic [3:0] m_en;
  int       m_prs_exp;
  int       prs_seen;
  int       total, bad;

  // Scoreboard
  int          q_cyc  [$];
  int          q_kind [$];
  logic [31:0] q_val  [$];
  string       q_name [$];

  function automatic void push(input int c, input int k, input logic [31:0] v, input string n);
    q_cyc.push_back(c); q_kind.push_back(k); q_val.push_back(v); q_name.push_back(n);
  endfunction

  function automatic logic [31:0] status(input int st);
    logic [3:0] t;
    logic [2:0] s3;
    t  = 4'(m_target);
    s3 = 3'(st);
    return {16'h0, m_ovf, m_unf, m_to, m_err, t, (st != 0), s3, 4'h0};
  endfunction

  function automatic logic [31:0] outv(input logic [3:0] h, input logic g,
                                       input logic [3:0] lf, input logic [3:0] en);
    return {19'h0, h, g, lf, en};
  endfunction

  function automatic void m_apply(input int s, input bit inc, input bit dec);
    if (inc && !dec) begin
      if (m_cnt[s] == 255) m_ovf = 1'b1; else m_cnt[s]++;
    end else if (dec && !inc) begin
      if (m_cnt[s] == 0) m_unf = 1'b1; else m_cnt[s]--;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NB; i++) m_cnt[i] = 0;
    m_ovf = 0; m_unf = 0; m_err = 0; m_to = 0;
    m_target = 0; m_en = 4'hF;
  endfunction

  function automatic void m_clr();
    m_ovf = 0; m_unf = 0; m_err = 0; m_to = 0;
  endfunction

  always @(negedge clk) begin
    logic [31:0] got;
    if (pr_start) prs_seen++;
    for (int i = q_cyc.size() - 1; i >= 0; i--) begin
      if (q_cyc[i] <= cyc) begin
        if (q_kind[i] == K_RD)       got = avs_ctrl_readdata;
        else if (q_kind[i] == K_OUT) got = outv(hold_pnode, coe_globalfreeze, coe_localfreeze, coe_enable);
        else                         got = 32'(pr_start);
        total++;
        if (q_cyc[i] < cyc || got !== q_val[i]) begin
          bad++;
          $display("FAIL %s @cycle %0d: got %h want %h", q_name[i], q_cyc[i], got, q_val[i]);
        end
        q_cyc.delete(i); q_kind.delete(i); q_val.delete(i); q_name.delete(i);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    avs_ctrl_write = 1'b1; avs_ctrl_address = a; avs_ctrl_writedata = d;
    @(negedge clk);
    avs_ctrl_write = 1'b0; avs_ctrl_writedata = '0;
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] e, input string n);
    avs_ctrl_read = 1'b1; avs_ctrl_address = a;
    push(cyc + 1, K_RD, e, n);
    @(negedge clk);
    avs_ctrl_read = 1'b0;
  endtask

  // One cycle of snooped traffic on slot s; non-handshaking sides get noise.
  task automatic hs(input int s, input bit inc, input bit dec);
    int r1, r2;
    r1 = $urandom_range(0, 2);
    r2 = $urandom_range(0, 2);
    pnv[s] = inc || r1 == 1; pnr[s]  = inc || r1 == 2;
    dv[s]  = dec || r2 == 1; dack[s] = dec || r2 == 2;
    m_apply(s, inc, dec);
    @(negedge clk);
    pnv = '0; pnr = '0; dv = '0; dack = '0;
  endtask

  task automatic pulse(input bit done, input bit error);
    pr_done = done; pr_error = error;
    @(negedge clk);
    pr_done = 1'b0; pr_error = 1'b0;
  endtask

  // outcome: 0 = pr_done, 1 = pr_error, 2 = both together
  task automatic run_pr(input int slot, input int outcome, input bit poke);
    int c, p, d, nout;
    logic [3:0] sel;
    sel  = 4'(1 << slot);
    nout = m_cnt[slot];
    c    = cyc;
    p    = c + 3 + FC;
    push(c + 1, K_OUT, outv(sel, 1'b0, 4'h0, m_en), "hold_rise");
    if (nout == 0) begin
      push(c + 2, K_OUT, outv(sel, 1'b0, 4'h0, m_en), "drain_unfrozen");
      push(p - FC, K_OUT, outv(sel, 1'b1, sel, m_en & ~sel), "freeze_on");
      push(p, K_PRS, 32'd1, "pr_start");
      push(p + 1, K_PRS, 32'd0, "pr_start_width");
    end
    csr_wr(2'd0, 32'h1 | 32'(slot << 4));
    m_target = slot;
    if (nout != 0) begin
      idle(1);
      csr_rd(2'd2, 32'(nout), "drain_count");
      csr_rd(2'd0, status(2), "drain_status");
      for (int j = 0; j < nout; j++) begin
        idle($urandom_range(0, 2));
        if (j == nout - 1) begin
          p = cyc + 1 + FC;
          push(p - FC, K_OUT, outv(sel, 1'b1, sel, m_en & ~sel), "freeze_on");
          push(p, K_PRS, 32'd1, "pr_start");
          push(p + 1, K_PRS, 32'd0, "pr_start_width");
        end
        hs(slot, 1'b0, 1'b1);
      end
    end
    m_prs_exp++;
    pulse(1'b1, 1'b0);
    wait_until(p);
    if (poke) begin
      csr_wr(2'd1, 32'h0);
      csr_wr(2'd0, 32'h31);
      csr_rd(2'd0, status(4), "busy_status");
    end
    idle($urandom_range(0, 3));
    d = cyc;
    if (outcome == 0) begin
      push(d + SC, K_OUT, outv(sel, 1'b1, sel, m_en & ~sel), "settle_frozen");
      m_en = m_en | sel;
      push(d + SC + 1, K_OUT, outv(4'h0, 1'b0, 4'h0, m_en), "released");
      pulse(1'b1, 1'b0);
      m_cnt[slot] = 0;
      wait_until(d + SC + 2);
      csr_rd(2'd0, status(0), "done_status");
      csr_rd(2'd2, 32'd0, "cnt_cleared");
    end else begin
      push(d + 1, K_OUT, outv(sel, 1'b1, sel, m_en & ~sel), "err_frozen");
      pulse(outcome == 2, 1'b1);
      m_err = 1'b1;
      csr_rd(2'd0, status(7), "err_status");
      m_en = m_en & ~sel;
      push(cyc + 1, K_OUT, outv(4'h0, 1'b0, 4'h0, m_en), "err_cleared");
      csr_wr(2'd0, 32'h100);
      m_clr();
      csr_rd(2'd0, status(0), "clr_status");
    end
  endtask

  initial begin
    int s, k, t, c, mask;
    m_reset();
    m_prs_exp = 0; prs_seen = 0; total = 0; bad = 0;
    idle(3);
    reset = 1'b0;

    // Reset values
    push(cyc + 1, K_OUT, outv(4'h0, 1'b0, 4'h0, 4'hF), "reset_outputs");
    csr_rd(2'd1, 32'hF, "reset_mask");
    csr_rd(2'd0, 32'h0, "reset_status");
    csr_rd(2'd2, 32'h0, "reset_count");

    // Clean PR of slot 2
    run_pr(2, 0, 1'b0);

    // Drain wait on slot 1
    repeat (3) hs(1, 1'b1, 1'b0);
    run_pr(1, 0, 1'b0);

    // PR failure with done and error together
    run_pr(3, 2, 1'b0);
    csr_wr(2'd1, 32'hF); m_en = 4'hF;

    // Protection while busy
    run_pr(0, 0, 1'b1);

    // Randomised sequences
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(2, 6)) begin
        s = $urandom_range(0, NB - 1);
        k = $urandom_range(0, 3);
        case (k)
          0: hs(s, 1'b1, 1'b0);
          1: hs(s, m_cnt[s] == 0, m_cnt[s] != 0);
          2: hs(s, 1'b1, 1'b1);
          default: hs(s, 1'b0, 1'b0);
        endcase
      end
      if ($urandom_range(0, 1) == 1) begin
        mask = $urandom_range(0, 15);
        csr_wr(2'd1, 32'(mask)); m_en = 4'(mask);
        csr_rd(2'd1, 32'(m_en), "mask_readback");
      end
      run_pr($urandom_range(0, NB - 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      csr_wr(2'd1, 32'hF); m_en = 4'hF;
    end

    // Counter edges on the latched target
    t = m_target;
    hs(t, 1'b1, 1'b0);
    hs(t, 1'b1, 1'b0);
    hs(t, 1'b1, 1'b1);
    csr_rd(2'd2, 32'(m_cnt[t]), "inc_dec_same_cycle");
    repeat (m_cnt[t] + 1) hs(t, 1'b0, 1'b1);
    csr_rd(2'd2, 32'd0, "dec_at_zero");
    csr_rd(2'd0, status(0), "unf_status");

    // Out-of-range target
    push(cyc + 1, K_OUT, outv(4'h0, 1'b0, 4'h0, m_en), "bad_target_no_hold");
    csr_wr(2'd0, 32'h51);
    m_err = 1'b1;
    csr_rd(2'd0, status(0), "bad_target_status");
    csr_wr(2'd0, 32'h100); m_clr();
    csr_rd(2'd0, status(0), "clr_flags");

    // Drain timeout on slot 0
    if (m_cnt[0] == 0) hs(0, 1'b1, 1'b0);
    c = cyc;
    push(c + 1, K_OUT, outv(4'h1, 1'b0, 4'h0, m_en), "tmo_hold");
    csr_wr(2'd0, 32'h01);
    m_target = 0;
    wait_until(c + 1000);
    csr_rd(2'd0, status(2), "tmo_still_drain");
    wait_until(c + 1030);
    m_err = 1'b1; m_to = 1'b1;
    push(cyc + 1, K_OUT, outv(4'h1, 1'b0, 4'h0, m_en & 4'hE), "tmo_outputs");
    csr_rd(2'd0, status(7), "tmo_status");
    m_en = m_en & 4'hE;
    push(cyc + 1, K_OUT, outv(4'h0, 1'b0, 4'h0, m_en), "tmo_cleared");
    csr_wr(2'd0, 32'h100); m_clr();
    csr_rd(2'd0, status(0), "tmo_idle");
    csr_rd(2'd1, 32'(m_en), "tmo_enable_low");
    repeat (m_cnt[0]) hs(0, 1'b0, 1'b1);
    csr_wr(2'd1, 32'hF); m_en = 4'hF;

    // Saturation on slot 0
    repeat (256) hs(0, 1'b1, 1'b0);
    csr_rd(2'd2, 32'd255, "saturated");
    csr_rd(2'd0, status(0), "ovf_status");

    // Reset, then reset in the middle of a sequence
    reset = 1'b1; idle(1); reset = 1'b0;
    m_reset();
    c = cyc;
    csr_wr(2'd0, 32'h11);
    wait_until(c + 4);
    push(c + 5, K_OUT, outv(4'h0, 1'b0, 4'h0, 4'hF), "mid_reset_outputs");
    reset = 1'b1; idle(1); reset = 1'b0;
    m_reset();
    csr_rd(2'd0, status(0), "mid_reset_status");
    csr_rd(2'd2, 32'd0, "mid_reset_count");

    idle(40);
    total++;
    if (prs_seen != m_prs_exp) begin
      bad++;
      $display("FAIL pr_start_count: got %0d want %0d", prs_seen, m_prs_exp);
    end
    total++;
    if (q_cyc.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q_cyc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/matchblock_pr_controller.md
# matchblock_pr_controller

Sequences partial reconfiguration of the match-block regions behind the Avalon fabric. For one selected slot it stops new pnodes, drains outstanding match results, freezes the slot, hands off to the PR engine, and re-enables the slot. It drives the per-slot `coe_localfreeze`/`coe_enable` and the shared `coe_globalfreeze` inputs of the match-block wrappers. It also tracks outstanding work per slot by snooping each slot's pnode and result handshakes.

## Interface
- NUM_BLOCKS, 4: number of match-block slots (1..16).
- CNT_W, 8: width of the per-slot outstanding counter.
- DRAIN_TIMEOUT, 1024: maximum cycles spent in DRAIN before aborting.
- FREEZE_CYCLES, 4: cycles the freeze is held before PR starts.
- SETTLE_CYCLES, 16: cycles the freeze is held after PR completes.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- avs_ctrl_write  in  1  CSR write strobe.
- avs_ctrl_read  in  1  CSR read strobe.
- avs_ctrl_address  in  2  CSR word address.
- avs_ctrl_writedata  in  32  CSR write data.
- avs_ctrl_readdata  out  32  CSR read data, registered.
- coe_localfreeze  out  NUM_BLOCKS  per-slot freeze.
- coe_globalfreeze  out  1  shared freeze; asserted together with the target's local freeze.
- coe_enable  out  NUM_BLOCKS  per-slot enable.
- hold_pnode  out  NUM_BLOCKS  tells the upstream dispatcher to stop offering pnodes to a slot.
- mon_pnode_valid, mon_pnode_ready  in  NUM_BLOCKS each  snooped pnode handshake.
- mon_data_valid, mon_data_ack  in  NUM_BLOCKS each  snooped result handshake.
- pr_start  out  1  one-cycle pulse to the PR engine.
- pr_done  in  1  PR completed successfully; single-cycle pulse.
- pr_error  in  1  PR failed; single-cycle pulse.

## Operation
- **Outstanding counters.** One counter per slot, always running.
  - +1 on `mon_pnode_valid & mon_pnode_ready`.
  - −1 on `mon_data_valid & mon_data_ack`.
  - Both in the same cycle: no change.
  - Increment at max: saturates and sets sticky `ovf`.
  - Decrement at 0: holds 0 and sets sticky `unf`.
  - A counter clears when its slot completes PR (ENABLE state).
- **CSR map.**
  - Address 0 write:
    - bit0 `start`, ignored unless state is IDLE.
    - bits[7:4] `target`. A target ≥ NUM_BLOCKS sets `err` and does not start.
    - bit8 `clr_err`: clears `err`, `timeout`, `ovf`, `unf`. In ERROR it also returns the FSM to IDLE.
  - Address 1 write: enable mask, bits[NUM_BLOCKS-1:0], applied directly to `coe_enable`. Ignored when not IDLE.
  - Address 2 write: ignored.
  - Address 0 read: `{16'b0, ovf, unf, timeout, err, target[3:0], busy, state[2:0], 4'b0}`, laid out as bit15 `ovf`, bit14 `unf`, bit13 `timeout`, bit12 `err`, bits[11:8] `target`, bit7 `busy`, bits[6:4] `state`.
  - Address 1 read: enable mask.
  - Address 2 read: outstanding count of the latched target, zero-extended.
- **FSM**, state encoding as listed:
  - **IDLE (0).** On a valid `start`: latch `target`, then go to HOLD.
  - **HOLD (1).** Assert `hold_pnode[target]`. After one cycle, go to DRAIN. The one cycle absorbs a handshake already in flight.
  - **DRAIN (2).** When `cnt[target]==0`, go to FREEZE. If the wait counter reaches DRAIN_TIMEOUT, set `timeout` and `err`, go to ERROR, and keep `hold_pnode`.
  - **FREEZE (3).**
    - On entry: clear `coe_enable[target]`; assert `coe_localfreeze[target]` and `coe_globalfreeze`.
    - After FREEZE_CYCLES, pulse `pr_start` and go to PRWAIT.
  - **PRWAIT (4).**
    - `pr_done`: go to SETTLE.
    - `pr_error`: set `err` and go to ERROR.
    - Both in the same cycle: `pr_error` wins.
  - **SETTLE (5).** Freeze stays asserted. After SETTLE_CYCLES, go to ENABLE.
  - **ENABLE (6).** Release both freezes, set `coe_enable[target]`, drop `hold_pnode[target]`, clear `cnt[target]`. Return to IDLE the next cycle.
  - **ERROR (7).**
    - Entered from DRAIN: freeze stays deasserted.
    - Entered from PRWAIT: freeze stays asserted.
    - `hold_pnode[target]` asserted; `coe_enable[target]` is 0 in both cases.
    - `clr_err` releases everything except `enable`, which stays 0, and returns to IDLE.
- **Busy.** `busy` = state ≠ IDLE.
- **Other slots.** Non-target slots are never touched by a sequence.

## Timing
- Reset values:
  - `coe_localfreeze` = 0, `coe_globalfreeze` = 0, `hold_pnode` = 0.
  - `coe_enable` = all 1s.
  - `pr_start` = 0, `avs_ctrl_readdata` = 0.
  - All counters and flags = 0; state = IDLE.
- **Reset mid-sequence:** all outputs return to their reset values on the next cycle, including releasing the freeze.
- **Readdata:** valid the cycle after `avs_ctrl_read`; holds its value otherwise.
- **Start latency:** from the CSR write cycle, `hold_pnode` rises 1 cycle later.
- **Best-case sequence:**
  - First `pr_start` pulse at cycle 3+FREEZE_CYCLES.
  - With outstanding = 0: write → HOLD(1) → DRAIN(1) → FREEZE(FREEZE_CYCLES) → pulse.
  - From `pr_done` to `coe_enable` high: SETTLE_CYCLES+1 cycles.
- **`pr_start`:** exactly one cycle wide. Ignored if repeated `pr_done` pulses arrive outside PRWAIT.
- **Drain timeout:** counted from DRAIN entry; the timeout fires on the cycle the count equals DRAIN_TIMEOUT.

## Test plan
- **Reset values.** Read address 1 after reset → `0xF` (NUM_BLOCKS=4); freezes 0; status 0.
- **Clean PR of slot 2.** Outstanding 0; write `0x21` to address 0. Required:
  - `hold_pnode` = `0b0100` at +1.
  - `pr_start` at +7.
  - Freeze held from +3 until 16 cycles after `pr_done`.
  - `coe_enable` returns to `0xF`; status returns to IDLE.
- **Drain wait.** Slot 1 accepts 3 pnodes and has acked 0 results. Start target 1: the FSM stays in DRAIN (address 2 reads 3) until 3 acks arrive, then `pr_start` fires FREEZE_CYCLES+1 cycles after the last ack.
- **Timeout.** Slot 0 has 1 outstanding that is never acked. Required:
  - After 1024 DRAIN cycles: state 7, `timeout` = 1, `err` = 1, no `pr_start`.
  - After `clr_err`: IDLE, `coe_enable[0]` = 0.
- **PR failure.** `pr_error` and `pr_done` asserted together in PRWAIT. Required:
  - ERROR with freeze still asserted.
  - `clr_err` releases the freeze; enable bit stays 0.
- **Counter edges and protection.**
  - Simultaneous inc/dec leaves the count unchanged.
  - Decrement at 0 sets `unf`.
  - A `start` write while busy and an enable-mask write while busy have no effect.
  - `target` = 5 sets `err` without a sequence.
